// File: rtl/popcount_pipe.sv
// Pipelined population count with valid/ready handshakes on both sides.
// Define POPCOUNT_ACC_EN to add the per-frame saturating accumulator (acc_* ports).
module popcount_pipe #(
   parameter int WIDTH = 32,
   parameter int LAT   = 3,
   parameter int ACC_W = 16
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [WIDTH-1:0]             in_data,
   input  logic                         in_last,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [$clog2(WIDTH+1)-1:0]   out_count
`ifdef POPCOUNT_ACC_EN
   ,
   output logic                         acc_valid,
   output logic [ACC_W-1:0]             acc_count,
   output logic                         acc_sat
`endif
);

   // Handshake semantics: a beat moves on a rising edge only when valid and
   // ready are both high. in_ready is combinational from out_ready and the
   // registered output valid; a stall freezes every stage in lockstep.

   localparam int CW    = $clog2(WIDTH + 1);
   localparam int NCH   = 1 << (LAT - 1);
   localparam int CHW   = (WIDTH + NCH - 1) / NCH;
   localparam int PADW  = NCH * CHW;
   localparam int NODES = 2 * NCH - 1;

   // Tree level s occupies NCH>>s consecutive entries of r_tree.
   function automatic int lvl_off(input int s);
      return 2 * NCH - 2 * (NCH >> s);
   endfunction

   logic                r_rdy;
   logic                r_in_vld;
   logic [WIDTH-1:0]    r_in_data;
   logic [LAT-1:0]      r_vld;
   logic [CW-1:0]       r_tree [NODES];

   logic                w_stall;
   logic                w_accept;
   logic [PADW-1:0]     w_pad;
   logic [CW-1:0]       w_leaf [NCH];

   assign w_stall   = r_vld[LAT-1] & ~out_ready;
   assign in_ready  = r_rdy & ~w_stall;
   assign w_accept  = in_valid & in_ready;
   assign out_valid = r_vld[LAT-1];
   assign out_count = r_tree[NODES-1];

   assign w_pad = PADW'(r_in_data);

   always_comb begin
      for (int c = 0; c < NCH; c++) begin
         w_leaf[c] = '0;
         for (int b = 0; b < CHW; b++) begin
            w_leaf[c] = w_leaf[c] + CW'(w_pad[c*CHW + b]);
         end
      end
   end

   // r_rdy keeps in_ready low during reset and until the first edge after it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rdy     <= 1'b0;
         r_in_vld  <= 1'b0;
         r_in_data <= '0;
      end else begin
         r_rdy <= 1'b1;
         if (!w_stall) begin
            r_in_vld <= w_accept;
            if (w_accept) begin
               r_in_data <= in_data;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_vld <= '0;
         for (int i = 0; i < NODES; i++) begin
            r_tree[i] <= '0;
         end
      end else if (!w_stall) begin
         r_vld[0] <= r_in_vld;
         for (int c = 0; c < NCH; c++) begin
            r_tree[c] <= w_leaf[c];
         end
         for (int s = 1; s < LAT; s++) begin
            r_vld[s] <= r_vld[s-1];
            for (int j = 0; j < (NCH >> s); j++) begin
               r_tree[lvl_off(s) + j] <= r_tree[lvl_off(s-1) + 2*j]
                                       + r_tree[lvl_off(s-1) + 2*j + 1];
            end
         end
      end
   end

`ifdef POPCOUNT_ACC_EN
   logic                r_in_last;
   logic [LAT-1:0]      r_last;
   logic [ACC_W-1:0]    r_acc;
   logic                r_sat;
   logic [ACC_W:0]      w_sum;
   logic                w_ovf;

   // Running total including the beat currently on the output.
   assign w_sum     = {1'b0, r_acc} + (ACC_W+1)'(out_count);
   assign w_ovf     = w_sum[ACC_W];
   assign acc_count = w_ovf ? {ACC_W{1'b1}} : w_sum[ACC_W-1:0];
   assign acc_sat   = r_sat | w_ovf;
   assign acc_valid = r_vld[LAT-1] & r_last[LAT-1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_in_last <= 1'b0;
         r_last    <= '0;
      end else if (!w_stall) begin
         if (w_accept) begin
            r_in_last <= in_last;
         end
         r_last[0] <= r_in_last;
         for (int s = 1; s < LAT; s++) begin
            r_last[s] <= r_last[s-1];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_acc <= '0;
         r_sat <= 1'b0;
      end else if (r_vld[LAT-1] && out_ready) begin
         if (r_last[LAT-1]) begin
            r_acc <= '0;
            r_sat <= 1'b0;
         end else begin
            r_acc <= acc_count;
            r_sat <= acc_sat;
         end
      end
   end
`else
   logic w_unused_last;
   assign w_unused_last = in_last;
`endif

endmodule
